// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared opcodes, state encoding and datapath mux codes for multicycle_control
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // Bit positions inside the one-hot opcode class vector.
    localparam int CLS_R       = 0;
    localparam int CLS_IMM     = 1;
    localparam int CLS_LOAD    = 2;
    localparam int CLS_STORE   = 3;
    localparam int CLS_BRANCH  = 4;
    localparam int CLS_J       = 5;
    localparam int CLS_JAL     = 6;
    localparam int CLS_ILLEGAL = 7;
    localparam int CLS_W       = 8;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_FAULT    = 4'd14
    } state_t;

    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_FUNCT   = 2'b10;
    localparam logic [1:0] ALU_OPIMM   = 2'b11;

    localparam logic [1:0] PCSRC_ALU   = 2'b00;
    localparam logic [1:0] PCSRC_OUT   = 2'b01;
    localparam logic [1:0] PCSRC_JUMP  = 2'b10;

    localparam logic [1:0] RDST_RT     = 2'b00;
    localparam logic [1:0] RDST_RD     = 2'b01;
    localparam logic [1:0] RDST_R31    = 2'b10;

    localparam logic [1:0] M2R_ALUOUT  = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_PC      = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_ctrl_opclass.sv
// rtl/mc_ctrl_opclass.sv - combinational opcode to one-hot instruction class decode
module mc_ctrl_opclass
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output logic [CLS_W-1:0]    o_class
);

    logic [5:0] w_op;

    assign w_op = i_opcode[5:0];

    always_comb begin
        o_class = '0;
        casez (w_op)
            OP_RTYPE:                          o_class[CLS_R]      = 1'b1;
            OP_REGIMM, 6'b0001??:              o_class[CLS_BRANCH] = 1'b1;
            OP_J:                              o_class[CLS_J]      = 1'b1;
            OP_JAL:                            o_class[CLS_JAL]    = 1'b1;
            // 001001..001111; 001000 is deliberately left illegal.
            6'b001001, 6'b00101?, 6'b0011??:   o_class[CLS_IMM]    = 1'b1;
            OP_LB, OP_LW:                      o_class[CLS_LOAD]   = 1'b1;
            OP_SB, OP_SW:                      o_class[CLS_STORE]  = 1'b1;
            default:                           o_class[CLS_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory-wait timeout
// Optional illegal-opcode trap enabled by MC_CTRL_ILLEGAL_TRAP_EN.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALU_OP_W    = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_byte,
    output logic                ir_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                fault,
    output logic                illegal_op
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_fault;
    logic               r_illegal;

    logic [CLS_W-1:0]   w_class;
    logic               w_timeout;
    logic [WAIT_W-1:0]  w_wait_inc;
    state_t             w_after_final;
    logic [1:0]         w_alu_op;

    mc_ctrl_opclass #(
        .OPCODE_W (OPCODE_W)
    ) u_opclass (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    // Saturate so that a disabled timeout (WAIT_MAX = 0) keeps the counter parked at zero.
    assign w_wait_inc    = (r_wait == WAIT_MAX) ? r_wait : r_wait + 1'b1;
    assign w_timeout     = (MEM_TIMEOUT != 0) && (r_wait == WAIT_MAX) && !mem_ready;
    assign w_after_final = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_fault   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    if (run) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_wait <= w_wait_inc;
                    end
                end
                S_DECODE: begin
                    r_wait <= '0;
                    if (w_class[CLS_R]) begin
                        r_state <= S_EXEC_R;
                    end else if (w_class[CLS_IMM]) begin
                        r_state <= S_EXEC_I;
                    end else if (w_class[CLS_LOAD] || w_class[CLS_STORE]) begin
                        r_state <= S_MEM_ADDR;
                    end else if (w_class[CLS_BRANCH]) begin
                        r_state <= S_BRANCH;
                    end else if (w_class[CLS_J]) begin
                        r_state <= S_JUMP;
                    end else if (w_class[CLS_JAL]) begin
                        r_state <= S_JAL;
                    end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        r_state   <= S_FAULT;
                        r_illegal <= 1'b1;
`else
                        r_state   <= w_after_final;
`endif
                    end
                end
                S_EXEC_R: r_state <= S_WB_R;
                S_EXEC_I: r_state <= S_WB_I;
                S_MEM_ADDR: begin
                    r_wait  <= '0;
                    r_state <= opcode[3] ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD, S_MEM_WR: begin
                    if (mem_ready) begin
                        r_wait  <= '0;
                        r_state <= (r_state == S_MEM_RD) ? S_MEM_WB : w_after_final;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_wait <= w_wait_inc;
                    end
                end
                S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL: begin
                    r_wait  <= '0;
                    r_state <= w_after_final;
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output decode: Moore per state, except the mem_ready-qualified strobes in wait states.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_byte      = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = RDST_RT;
        mem_to_reg    = M2R_ALUOUT;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        w_alu_op      = ALU_ADD;
        instr_done    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
                instr_done = w_class[CLS_ILLEGAL];
`endif
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                w_alu_op  = ALU_FUNCT;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = RDST_RD;
                instr_done = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_alu_op  = ALU_OPIMM;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                mem_byte = (opcode[1:0] == 2'b00);
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                mem_byte   = (opcode[1:0] == 2'b00);
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REG;
                w_alu_op      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_OUT;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = RDST_R31;
                mem_to_reg = M2R_PC;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_op     = ALU_OP_W'(w_alu_op);
    assign fault      = r_fault;
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_byte;
    logic       ir_write, reg_write, alu_src_a, instr_done, fault, illegal_op;
    logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic [19:0] w_ctrl;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .OPCODE_W    (6),
        .ALU_OP_W    (2),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_byte      (mem_byte),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .fault         (fault),
        .illegal_op    (illegal_op)
    );

    assign w_ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, mem_byte,
                     ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, instr_done};

    function automatic logic [19:0] cw(input logic pcw, input logic pcwc, input logic [1:0] pcs,
                                       input logic iod, input logic mr, input logic mw, input logic mb,
                                       input logic irw, input logic [1:0] rd, input logic [1:0] m2r,
                                       input logic rw, input logic a, input logic [1:0] b,
                                       input logic [1:0] op, input logic done);
        return {pcw, pcwc, pcs, iod, mr, mw, mb, irw, rd, m2r, rw, a, b, op, done};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: apply mem_ready, check outputs, advance to the next falling edge.
    task automatic step(input string tag, input logic rdy, input logic [19:0] exp);
        mem_ready = rdy;
        #1;
        check_eq(tag, {12'd0, w_ctrl}, {12'd0, exp});
        @(negedge clk);
    endtask

    logic [19:0] E_ZERO, E_F_RDY, E_F_WAIT, E_DEC, E_DEC_NOP, E_EXR, E_WBR, E_EXI, E_WBI, E_MA;
    logic [19:0] E_RD_W, E_MWB, E_WR_B_WAIT, E_WR_B_DONE, E_BR, E_J, E_JAL;

    initial begin
        E_ZERO      = 20'd0;
        E_F_RDY     = cw(1,0,2'b00,0,1,0,0,1,2'b00,2'b00,0,0,2'b01,2'b00,0);
        E_F_WAIT    = cw(0,0,2'b00,0,1,0,0,0,2'b00,2'b00,0,0,2'b01,2'b00,0);
        E_DEC       = cw(0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,0);
        E_DEC_NOP   = cw(0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,1);
        E_EXR       = cw(0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,2'b10,0);
        E_WBR       = cw(0,0,2'b00,0,0,0,0,0,2'b01,2'b00,1,0,2'b00,2'b00,1);
        E_EXI       = cw(0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,2'b11,0);
        E_WBI       = cw(0,0,2'b00,0,0,0,0,0,2'b00,2'b00,1,0,2'b00,2'b00,1);
        E_MA        = cw(0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,2'b00,0);
        E_RD_W      = cw(0,0,2'b00,1,1,0,0,0,2'b00,2'b00,0,0,2'b00,2'b00,0);
        E_MWB       = cw(0,0,2'b00,0,0,0,0,0,2'b00,2'b01,1,0,2'b00,2'b00,1);
        E_WR_B_WAIT = cw(0,0,2'b00,1,0,1,1,0,2'b00,2'b00,0,0,2'b00,2'b00,0);
        E_WR_B_DONE = cw(0,0,2'b00,1,0,1,1,0,2'b00,2'b00,0,0,2'b00,2'b00,1);
        E_BR        = cw(0,1,2'b01,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,2'b01,1);
        E_J         = cw(1,0,2'b10,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,2'b00,1);
        E_JAL       = cw(1,0,2'b10,0,0,0,0,0,2'b10,2'b10,1,0,2'b00,2'b00,1);

        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("reset_ctrl", {12'd0, w_ctrl}, 32'd0);
        check_eq("reset_fault", {31'd0, fault}, 32'd0);
        check_eq("reset_illegal", {31'd0, illegal_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // R-type, then back-to-back instructions with run held high
        run = 1'b1;
        opcode = 6'b000000;
        step("r_idle", 1'b1, E_ZERO);
        step("r_fetch", 1'b1, E_F_RDY);
        step("r_decode", 1'b1, E_DEC);
        step("r_exec", 1'b1, E_EXR);
        step("r_wb", 1'b1, E_WBR);

        opcode = 6'b100011;
        step("lw_fetch", 1'b1, E_F_RDY);
        step("lw_decode", 1'b1, E_DEC);
        step("lw_addr", 1'b1, E_MA);
        for (int i = 0; i < 3; i++) step("lw_rd_wait", 1'b0, E_RD_W);
        step("lw_rd_rdy", 1'b1, E_RD_W);
        step("lw_wb", 1'b1, E_MWB);

        opcode = 6'b101000;
        step("sb_fetch", 1'b1, E_F_RDY);
        step("sb_decode", 1'b1, E_DEC);
        step("sb_addr", 1'b1, E_MA);
        step("sb_wr_wait", 1'b0, E_WR_B_WAIT);
        step("sb_wr_done", 1'b1, E_WR_B_DONE);

        opcode = 6'b000011;
        step("jal_fetch", 1'b1, E_F_RDY);
        step("jal_decode", 1'b1, E_DEC);
        step("jal_exec", 1'b1, E_JAL);

        opcode = 6'b000100;
        step("beq_fetch", 1'b1, E_F_RDY);
        step("beq_decode", 1'b1, E_DEC);
        step("beq_exec", 1'b1, E_BR);

        opcode = 6'b000010;
        step("j_fetch", 1'b1, E_F_RDY);
        step("j_decode", 1'b1, E_DEC);
        step("j_exec", 1'b1, E_J);

        opcode = 6'b001001;
        step("imm_fetch", 1'b1, E_F_RDY);
        step("imm_decode", 1'b1, E_DEC);
        step("imm_exec", 1'b1, E_EXI);
        step("imm_wb", 1'b1, E_WBI);

        opcode = 6'b111111;
        step("ill_fetch", 1'b1, E_F_RDY);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        step("ill_decode", 1'b1, E_DEC);
        step("ill_fault_state", 1'b1, E_ZERO);
        check_eq("ill_illegal_op", {31'd0, illegal_op}, 32'd1);
        check_eq("ill_fault_flag", {31'd0, fault}, 32'd0);
`else
        step("ill_decode_nop", 1'b1, E_DEC_NOP);
        step("ill_next_fetch", 1'b1, E_F_RDY);
        check_eq("ill_illegal_op", {31'd0, illegal_op}, 32'd0);
        // run low on the final cycle sends the FSM to IDLE
        opcode = 6'b000010;
        step("stop_decode", 1'b1, E_DEC);
        run = 1'b0;
        step("stop_jump", 1'b1, E_J);
        step("stop_idle", 1'b1, E_ZERO);
`endif

        // Reset mid-flight, then a ready arriving on the 16th wait cycle still wins
        rst = 1'b1;
        #1;
        check_eq("rst_async_ctrl", {12'd0, w_ctrl}, 32'd0);
        check_eq("rst_async_illegal", {31'd0, illegal_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        opcode = 6'b000000;
        step("edge_idle", 1'b0, E_ZERO);
        for (int i = 0; i < 15; i++) step("edge_fetch_wait", 1'b0, E_F_WAIT);
        step("edge_fetch_rdy16", 1'b1, E_F_RDY);
        step("edge_decode", 1'b1, E_DEC);
        check_eq("edge_no_fault", {31'd0, fault}, 32'd0);
        step("edge_exec", 1'b1, E_EXR);
        step("edge_wb", 1'b1, E_WBR);

        // 16 stalled fetch cycles time out into FAULT
        for (int i = 0; i < 16; i++) step("to_fetch_wait", 1'b0, E_F_WAIT);
        step("to_fault_state", 1'b1, E_ZERO);
        check_eq("to_fault_flag", {31'd0, fault}, 32'd1);
        step("to_fault_sticky", 1'b1, E_ZERO);
        check_eq("to_fault_hold", {31'd0, fault}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("to_rst_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        step("to_rst_idle", 1'b1, E_ZERO);
        run = 1'b1;
        step("to_rst_idle_run", 1'b1, E_ZERO);
        step("to_rst_fetch", 1'b1, E_F_RDY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
